// File: rtl/gelato_warp_fetch_scheduler.sv
// rtl/gelato_warp_fetch_scheduler.sv - warp fetch scheduler between the PC table and ifetch
// Picks one eligible warp per issue and holds it on a registered valid/ready port.
module gelato_warp_fetch_scheduler #(
  parameter int WARP_NUM     = 32,
  parameter int PC_WIDTH     = 32,
  parameter int SPLIT_WIDTH  = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int POLICY       = 0,
  localparam int WW = $clog2(WARP_NUM),
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rdy,
  input  logic [WARP_NUM-1:0]             warp_valid,
  input  logic [WARP_NUM*PC_WIDTH-1:0]    warp_pc,
  input  logic [WARP_NUM*SPLIT_WIDTH-1:0] warp_split,
  input  logic                            act_valid,
  input  logic [WW-1:0]                   act_warp,
  output logic                            req_valid,
  input  logic                            req_ready,
  output logic [PC_WIDTH-1:0]             req_pc,
  output logic [WW-1:0]                   req_warp,
  output logic [SPLIT_WIDTH-1:0]          req_split,
  output logic [CW-1:0]                   inflight
);

  logic                   req_valid_q, req_valid_d;
  logic [PC_WIDTH-1:0]    req_pc_q, req_pc_d;
  logic [WW-1:0]          req_warp_q, req_warp_d;
  logic [SPLIT_WIDTH-1:0] req_split_q, req_split_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [WARP_NUM-1:0]    disabled_q, disabled_d;
  logic [WW-1:0]          last_warp_q, last_warp_d;

  logic                   xfer;
  logic                   act_hit;
  logic                   act_dec;
  logic                   load;
  logic [WARP_NUM-1:0]    eligible;
  logic                   sel_found;
  logic [WW-1:0]          sel_warp;

  // Explicit modulo so non-power-of-two warp counts wrap correctly.
  function automatic logic [WW-1:0] wrap_add(input logic [WW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= WARP_NUM) begin
      sum = sum - WARP_NUM;
    end
    return sum[WW-1:0];
  endfunction

  always_comb begin
    eligible = '0;
    for (int i = 0; i < WARP_NUM; i++) begin
      eligible[i] = warp_valid[i] & ~disabled_q[i] &
                    ~(req_valid_q & (int'(req_warp_q) == i));
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_warp  = '0;
    if (POLICY == 1 && eligible[last_warp_q]) begin
      sel_found = 1'b1;
      sel_warp  = last_warp_q;
    end
    for (int k = 1; k <= WARP_NUM; k++) begin
      if (!sel_found && eligible[wrap_add(last_warp_q, k)]) begin
        sel_found = 1'b1;
        sel_warp  = wrap_add(last_warp_q, k);
      end
    end
  end

  always_comb begin
    xfer    = req_valid_q & req_ready & rdy;
    act_hit = act_valid & rdy & disabled_q[act_warp];
    // A warp being transferred keeps its disable; its reactivation cannot count.
    act_dec = act_hit & ~(xfer & (act_warp == req_warp_q)) & (inflight_q != '0);

    disabled_d = disabled_q;
    if (act_hit) begin
      disabled_d[act_warp] = 1'b0;
    end
    if (xfer) begin
      disabled_d[req_warp_q] = 1'b1;
    end

    inflight_d = inflight_q;
    if (xfer && !act_dec) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!xfer && act_dec) begin
      inflight_d = inflight_q - CW'(1);
    end

    last_warp_d = xfer ? req_warp_q : last_warp_q;

    req_valid_d = req_valid_q;
    req_pc_d    = req_pc_q;
    req_warp_d  = req_warp_q;
    req_split_d = req_split_q;
    load = rdy & (~req_valid_q | xfer) & (int'(inflight_d) < MAX_INFLIGHT) & sel_found;
    if (load) begin
      req_valid_d = 1'b1;
      req_warp_d  = sel_warp;
      req_pc_d    = warp_pc[int'(sel_warp)*PC_WIDTH +: PC_WIDTH];
      req_split_d = warp_split[int'(sel_warp)*SPLIT_WIDTH +: SPLIT_WIDTH];
    end else if (xfer) begin
      req_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
      req_warp_q  <= '0;
      req_split_q <= '0;
      inflight_q  <= '0;
      disabled_q  <= '0;
      last_warp_q <= WW'(WARP_NUM - 1);
    end else begin
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      req_warp_q  <= req_warp_d;
      req_split_q <= req_split_d;
      inflight_q  <= inflight_d;
      disabled_q  <= disabled_d;
      last_warp_q <= last_warp_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_pc    = req_pc_q;
  assign req_warp  = req_warp_q;
  assign req_split = req_split_q;
  assign inflight  = inflight_q;

  a_act_range: assert property (@(posedge clk) disable iff (!rst_n)
    act_valid |-> (int'(act_warp) < WARP_NUM));
  a_inflight_max: assert property (@(posedge clk) disable iff (!rst_n)
    int'(inflight_q) <= MAX_INFLIGHT);
  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (req_valid_q && !req_ready) |=> (req_valid_q && $stable(req_pc_q) &&
                                     $stable(req_warp_q) && $stable(req_split_q)));

endmodule

// File: tb/tb_gelato_warp_fetch_scheduler.sv
// tb/tb_gelato_warp_fetch_scheduler.sv - directed and randomized bench with a behavioural model
module tb_gelato_warp_fetch_scheduler;
  localparam int NW = 8;
  localparam int PW = 16;
  localparam int SW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              rdy;
  logic [NW-1:0]     warp_valid;
  logic [NW*PW-1:0]  warp_pc;
  logic [NW*SW-1:0]  warp_split;
  logic              act_v [2];
  logic [2:0]        act_w [2];
  logic              rr [2];
  logic              req_valid0, req_valid1;
  logic [PW-1:0]     req_pc0, req_pc1;
  logic [2:0]        req_warp0, req_warp1;
  logic [SW-1:0]     req_split0, req_split1;
  logic [1:0]        inflight0;
  logic [2:0]        inflight1;

  gelato_warp_fetch_scheduler #(.WARP_NUM(NW), .PC_WIDTH(PW), .SPLIT_WIDTH(SW),
                                .MAX_INFLIGHT(2), .POLICY(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .warp_valid(warp_valid), .warp_pc(warp_pc),
    .warp_split(warp_split), .act_valid(act_v[0]), .act_warp(act_w[0]),
    .req_valid(req_valid0), .req_ready(rr[0]), .req_pc(req_pc0), .req_warp(req_warp0),
    .req_split(req_split0), .inflight(inflight0));

  gelato_warp_fetch_scheduler #(.WARP_NUM(NW), .PC_WIDTH(PW), .SPLIT_WIDTH(SW),
                                .MAX_INFLIGHT(4), .POLICY(1)) u_greedy (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .warp_valid(warp_valid), .warp_pc(warp_pc),
    .warp_split(warp_split), .act_valid(act_v[1]), .act_warp(act_w[1]),
    .req_valid(req_valid1), .req_ready(rr[1]), .req_pc(req_pc1), .req_warp(req_warp1),
    .req_split(req_split1), .inflight(inflight1));

  int n_checks = 0;
  int n_pass   = 0;

  int m_val [2];
  int m_warp [2];
  int m_pc [2];
  int m_split [2];
  int m_inf [2];
  int m_last [2];
  bit m_dis [2][NW];
  int maxi [2] = '{2, 4};
  int pol [2]  = '{0, 1};

  int iss [2][$];
  int pend_t [2][$];
  int pend_w [2][$];
  int cyc = 0;
  bit auto_act = 1'b0;
  bit rand_act = 1'b0;
  int act_dly = 2;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int o_val(input int i);
    return (i == 0) ? int'(req_valid0) : int'(req_valid1);
  endfunction
  function automatic int o_warp(input int i);
    return (i == 0) ? int'(req_warp0) : int'(req_warp1);
  endfunction
  function automatic int o_pc(input int i);
    return (i == 0) ? int'(req_pc0) : int'(req_pc1);
  endfunction
  function automatic int o_split(input int i);
    return (i == 0) ? int'(req_split0) : int'(req_split1);
  endfunction
  function automatic int o_inf(input int i);
    return (i == 0) ? int'(inflight0) : int'(inflight1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_warp[i] = 0; m_pc[i] = 0; m_split[i] = 0;
      m_inf[i] = 0; m_last[i] = NW - 1;
      for (int w = 0; w < NW; w++) m_dis[i][w] = 1'b0;
      iss[i].delete(); pend_t[i].delete(); pend_w[i].delete();
    end
  endtask

  // One clock of scheduler behaviour, stated from the rules: who moves, who counts, who is next.
  task automatic model_step(input int i);
    bit xf, dec;
    bit elig [NW];
    int nxt, pick, cand;
    if (!rdy) return;
    xf = (m_val[i] != 0) && rr[i];
    for (int w = 0; w < NW; w++)
      elig[w] = warp_valid[w] && !m_dis[i][w] && !((m_val[i] != 0) && m_warp[i] == w);
    dec = act_v[i] && m_dis[i][act_w[i]] && !(xf && int'(act_w[i]) == m_warp[i]) && m_inf[i] > 0;
    if (act_v[i] && m_dis[i][act_w[i]]) m_dis[i][act_w[i]] = 1'b0;
    if (xf) m_dis[i][m_warp[i]] = 1'b1;
    nxt = m_inf[i] + (xf ? 1 : 0) - (dec ? 1 : 0);
    pick = -1;
    if (pol[i] == 1 && elig[m_last[i]]) pick = m_last[i];
    for (int k = 1; k <= NW; k++) begin
      cand = (m_last[i] + k) % NW;
      if (pick < 0 && elig[cand]) pick = cand;
    end
    if (xf) m_last[i] = m_warp[i];
    m_inf[i] = nxt;
    if ((m_val[i] == 0 || xf) && nxt < maxi[i] && pick >= 0) begin
      m_val[i]   = 1;
      m_warp[i]  = pick;
      m_pc[i]    = int'(warp_pc[pick*PW +: PW]);
      m_split[i] = int'(warp_split[pick*SW +: SW]);
    end else if (xf) begin
      m_val[i] = 0;
    end
  endtask

  task automatic step();
    for (int i = 0; i < 2; i++) begin
      if (rdy && o_val(i) != 0 && rr[i]) begin
        iss[i].push_back(o_warp(i));
        if (auto_act) begin
          pend_t[i].push_back(cyc + 1 + act_dly);
          pend_w[i].push_back(o_warp(i));
        end
      end
      if (auto_act) begin
        act_v[i] = 1'b0;
        if (rdy && pend_t[i].size() > 0 && pend_t[i][0] <= cyc + 1) begin
          void'(pend_t[i].pop_front());
          act_v[i] = 1'b1;
          act_w[i] = 3'(pend_w[i].pop_front());
        end else if (rand_act && $urandom_range(7) == 0) begin
          act_v[i] = 1'b1;
          act_w[i] = 3'($urandom_range(NW - 1));
        end
      end
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("valid%0d", i), o_val(i), m_val[i]);
      if (m_val[i] != 0) begin
        check($sformatf("warp%0d", i), o_warp(i), m_warp[i]);
        check($sformatf("pc%0d", i), o_pc(i), m_pc[i]);
        check($sformatf("split%0d", i), o_split(i), m_split[i]);
      end
      check($sformatf("inflight%0d", i), o_inf(i), m_inf[i]);
    end
  endtask

  task automatic do_reset();
    act_v[0] = 1'b0; act_v[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_valid%0d", i), o_val(i), 0);
      check($sformatf("rst_pc%0d", i), o_pc(i), 0);
      check($sformatf("rst_warp%0d", i), o_warp(i), 0);
      check($sformatf("rst_split%0d", i), o_split(i), 0);
      check($sformatf("rst_inflight%0d", i), o_inf(i), 0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_a [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0; rdy = 1'b1; warp_valid = '0; warp_pc = '0; warp_split = '0;
    act_v[0] = 1'b0; act_v[1] = 1'b0; act_w[0] = '0; act_w[1] = '0;
    rr[0] = 1'b1; rr[1] = 1'b1;
    for (int k = 0; k < NW; k++) begin
      warp_pc[k*PW +: PW]    = 16'(100 + k);
      warp_split[k*SW +: SW] = 5'(k + 3);
    end
    model_reset();
    @(negedge clk);

    // Round-robin order with reactivation two cycles after each transfer
    do_reset();
    warp_valid = 8'h0F; auto_act = 1'b1; act_dly = 2;
    step();
    check("a_first_valid", int'(req_valid0), 1);
    check("a_first_warp", int'(req_warp0), 0);
    repeat (24) step();
    check("a_issue_count", int'(iss[0].size() >= 5), 1);
    for (int k = 0; k < 5; k++) check($sformatf("a_order%0d", k), iss[0][k], exp_a[k]);

    // Inflight limit stalls the port, a reactivation releases it
    auto_act = 1'b0;
    do_reset();
    warp_valid = 8'hFF;
    repeat (6) step();
    check("b_issue_count", iss[0].size(), 2);
    check("b_issue0", iss[0][0], 0);
    check("b_issue1", iss[0][1], 1);
    check("b_stalled", int'(req_valid0), 0);
    check("b_inflight", int'(inflight0), 2);
    act_v[0] = 1'b1; act_w[0] = 3'd0;
    step();
    act_v[0] = 1'b0;
    check("b_resume_valid", int'(req_valid0), 1);
    check("b_resume_warp", int'(req_warp0), 2);

    // Greedy regrants the last warp once it is reactivated
    do_reset();
    warp_valid = 8'h02;
    step(); step();
    check("c_first_count", iss[1].size(), 1);
    check("c_first_warp", iss[1][0], 1);
    act_v[1] = 1'b1; act_w[1] = 3'd1;
    step();
    act_v[1] = 1'b0;
    warp_valid = 8'h0F;
    step();
    check("c_regrant_valid", int'(req_valid1), 1);
    check("c_regrant_warp", int'(req_warp1), 1);

    // Backpressure holds the sampled payload
    do_reset();
    rr[1] = 1'b0; warp_valid = 8'h08; warp_pc[3*PW +: PW] = 16'h1234;
    step();
    for (int k = 0; k < 5; k++) begin
      warp_pc[3*PW +: PW] = 16'($urandom_range(16'hFFFF));
      warp_valid = (k >= 3) ? 8'h00 : 8'h08;
      step();
      check("d_hold_valid", int'(req_valid1), 1);
      check("d_hold_pc", int'(req_pc1), 'h1234);
    end
    warp_valid = 8'h08; rr[1] = 1'b1;
    repeat (4) step();
    check("d_xfer_count", iss[1].size(), 1);

    // Same-cycle transfer and reactivation
    do_reset();
    warp_valid = 8'h20;
    step();
    act_v[0] = 1'b1; act_w[0] = 3'd5;
    step();
    act_v[0] = 1'b0;
    check("e_inflight", int'(inflight0), 1);
    repeat (3) step();
    check("e_stays_disabled", int'(req_valid0), 0);
    check("e_issue_count", iss[0].size(), 1);
    do_reset();
    warp_valid = 8'hC0;
    step(); step();
    check("e2_warp", int'(req_warp0), 7);
    check("e2_inflight", int'(inflight0), 1);
    act_v[0] = 1'b1; act_w[0] = 3'd6;
    step();
    act_v[0] = 1'b0;
    check("e2_inflight_kept", int'(inflight0), 1);

    // Global enable freeze, then reset mid-request
    do_reset();
    warp_valid = 8'hFF;
    step();
    rdy = 1'b0;
    repeat (3) begin
      step();
      check("f_frozen_valid", int'(req_valid0), 1);
      check("f_frozen_warp", int'(req_warp0), 0);
      check("f_frozen_inflight", int'(inflight0), 0);
    end
    check("f_no_xfer", iss[0].size(), 0);
    rdy = 1'b1;
    step();
    check("f_xfer", iss[0].size(), 1);
    do_reset();
    step();
    check("f_post_reset_valid", int'(req_valid0), 1);
    check("f_post_reset_warp", int'(req_warp0), 0);

    // Randomized traffic against the model
    do_reset();
    auto_act = 1'b1; rand_act = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if (n % 250 == 249) do_reset();
      rdy = ($urandom_range(9) != 0);
      warp_valid = 8'($urandom_range(255));
      for (int k = 0; k < NW; k++) begin
        if ($urandom_range(3) == 0) warp_pc[k*PW +: PW] = 16'($urandom_range(16'hFFFF));
        if ($urandom_range(3) == 0) warp_split[k*SW +: SW] = 5'($urandom_range(31));
      end
      rr[0] = ($urandom_range(3) != 0);
      rr[1] = ($urandom_range(3) != 0);
      act_dly = $urandom_range(1, 6);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
